// File: rtl/oled_spi_writer_if.sv
// rtl/oled_spi_writer_if.sv - write-strobe and SPI panel pin bundle for oled_spi_writer
//
// Purpose: groups the sequencer-facing push port and the panel-facing SPI pins.
// Signals:
//   data_in      8  byte to transmit
//   dc_in        1  D/C value for data_in (0 = command, 1 = data)
//   write_enable 1  one-cycle push strobe
//   buffer_full  1  FIFO holds DEPTH entries
//   busy         1  FIFO non-empty or frame in progress
//   overflow     1  sticky dropped-write flag
//   spi_cs       1  chip select, active low
//   spi_clk      1  SPI clock, mode 0
//   spi_mosi     1  serial data, MSB first
//   oled_dc      1  D/C for the current frame
// Modports: master = sequencer/panel side, slave = the writer itself.
interface oled_spi_writer_if;
    logic [7:0] data_in;
    logic       dc_in;
    logic       write_enable;
    logic       buffer_full;
    logic       busy;
    logic       overflow;
    logic       spi_cs;
    logic       spi_clk;
    logic       spi_mosi;
    logic       oled_dc;

    modport master (
        output data_in, dc_in, write_enable,
        input  buffer_full, busy, overflow, spi_cs, spi_clk, spi_mosi, oled_dc
    );

    modport slave (
        input  data_in, dc_in, write_enable,
        output buffer_full, busy, overflow, spi_cs, spi_clk, spi_mosi, oled_dc
    );
endinterface

// File: rtl/oled_spi_writer.sv
// rtl/oled_spi_writer.sv - byte FIFO plus mode-0 SPI serialiser with per-byte D/C
//
// Purpose: buffers {dc, data} bytes pushed by the sequencer and shifts each
// one MSB-first onto the panel SPI pins, one chip-select frame per byte.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high
//   bus    slave modport of oled_spi_writer_if (push port + SPI pins + status)
// Parameters:
//   DEPTH    FIFO entries, power of two, >= 2
//   CLK_DIV  system cycles per SPI half-period, >= 1
module oled_spi_writer #(
    parameter int DEPTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               reset,
    oled_spi_writer_if.slave   bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          mosi_q, mosi_d;
    logic          cs_q, cs_d;
    logic          sclk_q, sclk_d;
    logic          dc_q, dc_d;

    logic       push, pop, div_done;
    logic [8:0] head;

    // A write while full is always dropped, even if a pop frees a slot this cycle.
    assign push     = bus.write_enable && !full_q;
    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign head     = mem_q[rd_ptr_q];
    assign div_done = (div_q == DIV_LAST);

    // FIFO storage is not reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.dc_in, bus.data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            div_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            mosi_q     <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            dc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            mosi_q     <= mosi_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            dc_q       <= dc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pop) state_d = S_SETUP;
            S_SETUP: if (div_done) state_d = S_SHIFT;
            // Leave after the low half of the last bit period.
            S_SHIFT: if (div_done && !sclk_q && (bit_q == 3'd7)) state_d = S_HOLD;
            S_HOLD:  if (div_done) state_d = S_GAP;
            S_GAP:   if (div_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        // Registered compare against the next count keeps full aligned with count_q.
        full_d     = (count_d == FULL_CNT);
        overflow_d = overflow_q || (bus.write_enable && full_q);

        // Half-period divider free-runs in every non-idle state and restarts per phase.
        div_d   = ((state_q == S_IDLE) || div_done) ? '0 : div_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        dc_d    = dc_q;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d = head[7:0];
                    mosi_d  = head[7];
                    dc_d    = head[8];
                    cs_d    = 1'b0;
                    bit_d   = '0;
                end
            end
            S_SETUP: begin
                if (div_done) sclk_d = 1'b1;
            end
            S_SHIFT: begin
                if (div_done) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        // Present the next bit on the falling edge; after the LSB mosi holds.
                        if (bit_q != 3'd7) begin
                            shift_d = {shift_q[6:0], 1'b0};
                            mosi_d  = shift_q[6];
                        end
                    end else if (bit_q != 3'd7) begin
                        sclk_d = 1'b1;
                        bit_d  = bit_q + 3'd1;
                    end
                end
            end
            S_HOLD: begin
                if (div_done) cs_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.buffer_full = full_q;
    assign bus.busy        = (count_q != '0) || (state_q != S_IDLE);
    assign bus.overflow    = overflow_q;
    assign bus.spi_cs      = cs_q;
    assign bus.spi_clk     = sclk_q;
    assign bus.spi_mosi    = mosi_q;
    assign bus.oled_dc     = dc_q;
endmodule

// File: tb/tb_oled_spi_writer.sv
// tb/tb_oled_spi_writer.sv - directed self-checking bench for oled_spi_writer
module tb_oled_spi_writer;
    localparam int DEPTH   = 8;
    localparam int CLK_DIV = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    oled_spi_writer_if bus ();

    oled_spi_writer #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame monitor, sampled on the falling edge.
    logic [7:0] fr_data [$];
    logic       fr_dc [$];
    int         fr_len [$];
    int         fr_start [$];
    logic       prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0, prev_full = 1'b0;
    logic [7:0] bits;
    int         nbits = 0;
    logic       cur_dc;
    int         cur_start = 0;
    int         last_rise = 0;
    int         busy_fall = 0;
    int         full_rise = -1;
    logic       saw_full = 1'b0;
    logic       dc_changed = 1'b0;

    always @(negedge clk) begin
        if (prev_cs === 1'b1 && bus.spi_cs === 1'b0) begin
            cur_start = cyc;
            cur_dc    = bus.oled_dc;
            nbits     = 0;
            bits      = '0;
        end
        if (bus.spi_cs === 1'b0 && bus.oled_dc !== cur_dc) dc_changed = 1'b1;
        if (prev_sclk === 1'b0 && bus.spi_clk === 1'b1) begin
            bits  = {bits[6:0], bus.spi_mosi};
            nbits = nbits + 1;
        end
        if (prev_cs === 1'b0 && bus.spi_cs === 1'b1) begin
            fr_data.push_back(bits);
            fr_dc.push_back(cur_dc);
            fr_len.push_back(cyc - cur_start);
            fr_start.push_back(cur_start);
            last_rise = cyc;
        end
        if (prev_busy === 1'b1 && bus.busy === 1'b0) busy_fall = cyc;
        if (prev_full === 1'b0 && bus.buffer_full === 1'b1 && full_rise < 0) full_rise = cyc;
        if (bus.buffer_full === 1'b1) saw_full = 1'b1;
        prev_cs   = bus.spi_cs;
        prev_sclk = bus.spi_clk;
        prev_busy = bus.busy;
        prev_full = bus.buffer_full;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        fr_data.delete();
        fr_dc.delete();
        fr_len.delete();
        fr_start.delete();
        saw_full   = 1'b0;
        dc_changed = 1'b0;
        full_rise  = -1;
    endtask

    // Inputs are driven 1 time unit after the rising edge; back-to-back calls keep the strobe high.
    task automatic push_byte(input logic [7:0] b, input logic dc);
        bus.data_in      = b;
        bus.dc_in        = dc;
        bus.write_enable = 1'b1;
        @(posedge clk);
        #1;
        bus.write_enable = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (bus.busy === 1'b0) break;
            @(posedge clk);
            #1;
        end
        check_eq(tag, bus.busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int w0;
    logic [7:0] burst [5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    initial begin
        bus.data_in      = '0;
        bus.dc_in        = 1'b0;
        bus.write_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check_eq("rst_cs", bus.spi_cs, 1'b1);
        check_eq("rst_clk", bus.spi_clk, 1'b0);
        check_eq("rst_mosi", bus.spi_mosi, 1'b0);
        check_eq("rst_dc", bus.oled_dc, 1'b0);
        check_eq("rst_full", bus.buffer_full, 1'b0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_ovf", bus.overflow, 1'b0);

        // Single byte
        @(negedge clk);
        @(posedge clk);
        #1;
        clear_mon();
        w0 = cyc;
        push_byte(8'h68, 1'b1);
        wait_idle("single_idle");
        check_eq("single_frames", fr_data.size(), 1);
        if (fr_data.size() == 1) begin
            check_eq("single_data", fr_data[0], 8'h68);
            check_eq("single_dc", fr_dc[0], 1'b1);
            check_eq("single_cs_low", fr_len[0], 18 * CLK_DIV);
            check_eq("single_latency", fr_start[0] - w0, 2);
        end
        check_eq("single_dc_stable", dc_changed, 1'b0);
        check_eq("single_busy_drop", busy_fall - last_rise, CLK_DIV);

        // Burst of five
        clear_mon();
        for (int i = 0; i < 5; i++) push_byte(burst[i], 1'b1);
        wait_idle("burst_idle");
        check_eq("burst_frames", fr_data.size(), 5);
        for (int i = 0; i < 5 && i < fr_data.size(); i++) begin
            check_eq($sformatf("burst_data%0d", i), fr_data[i], burst[i]);
            if (i > 0) check_eq($sformatf("burst_space%0d", i), fr_start[i] - fr_start[i-1], 19 * CLK_DIV + 1);
        end
        check_eq("burst_ovf", bus.overflow, 1'b0);
        check_eq("burst_never_full", saw_full, 1'b0);

        // Overflow
        clear_mon();
        w0 = cyc;
        for (int i = 0; i < 12; i++) push_byte(8'(i), 1'b0);
        check_eq("ovf_flag", bus.overflow, 1'b1);
        check_eq("ovf_full_rise", full_rise - w0, 9);
        wait_idle("ovf_idle");
        check_eq("ovf_sticky", bus.overflow, 1'b1);
        check_eq("ovf_frames", fr_data.size(), 9);
        for (int i = 0; i < 9 && i < fr_data.size(); i++)
            check_eq($sformatf("ovf_data%0d", i), fr_data[i], 8'(i));
        pulse_reset();
        check_eq("ovf_cleared", bus.overflow, 1'b0);

        // D/C per byte
        clear_mon();
        push_byte(8'hAF, 1'b0);
        push_byte(8'h55, 1'b1);
        push_byte(8'h81, 1'b0);
        wait_idle("dc_idle");
        check_eq("dc_frames", fr_data.size(), 3);
        if (fr_data.size() == 3) begin
            check_eq("dc0", fr_dc[0], 1'b0);
            check_eq("dc1", fr_dc[1], 1'b1);
            check_eq("dc2", fr_dc[2], 1'b0);
            check_eq("dc_data0", fr_data[0], 8'hAF);
            check_eq("dc_data1", fr_data[1], 8'h55);
            check_eq("dc_data2", fr_data[2], 8'h81);
        end
        check_eq("dc_stable", dc_changed, 1'b0);

        // Reset mid-frame during bit 4 with three more queued
        clear_mon();
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        push_byte(8'h33, 1'b1);
        push_byte(8'h44, 1'b1);
        for (int i = 0; i < 500; i++) begin
            if (bus.spi_cs === 1'b0 && nbits == 4) break;
            @(posedge clk);
            #1;
        end
        check_eq("midrst_reached", nbits, 4);
        pulse_reset();
        check_eq("midrst_cs", bus.spi_cs, 1'b1);
        check_eq("midrst_clk", bus.spi_clk, 1'b0);
        check_eq("midrst_busy", bus.busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        clear_mon();
        repeat (100) @(posedge clk);
        #1;
        check_eq("midrst_no_frames", fr_data.size(), 0);
        check_eq("midrst_still_idle", bus.busy, 1'b0);
        push_byte(8'hC3, 1'b1);
        wait_idle("midrst_idle");
        check_eq("midrst_new_frames", fr_data.size(), 1);
        if (fr_data.size() == 1) check_eq("midrst_new_data", fr_data[0], 8'hC3);

        // Push on the pop cycle
        clear_mon();
        push_byte(8'hA5, 1'b0);
        push_byte(8'h5A, 1'b1);
        check_eq("pp_not_full", bus.buffer_full, 1'b0);
        wait_idle("pp_idle");
        check_eq("pp_frames", fr_data.size(), 2);
        if (fr_data.size() == 2) begin
            check_eq("pp_data0", fr_data[0], 8'hA5);
            check_eq("pp_data1", fr_data[1], 8'h5A);
            check_eq("pp_dc1", fr_dc[1], 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
